gtxe2_chnl_tx_oob_seq: RTL and testbench

Parametrised TX out-of-band (OOB) burst sequencer for the GTXE2 channel model. It generalises the fixed COMINIT/COMWAKE generation in the TX path to programmable burst/gap timing and burst count, and adds a COMSAS mode, abort, and a request-collision flag. It sits between the TX OOB control inputs and the serializer, driving burst-enable and line-idle controls in the TXUSRCLK2 domain.

---
 rtl/gtxe2_chnl_tx_oob_seq_pkg.sv | 17 +
 rtl/gtxe2_oob_timer.sv | 18 +
 rtl/gtxe2_chnl_tx_oob_seq.sv | 118 +++++++++++
 tb/tb_gtxe2_chnl_tx_oob_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/gtxe2_chnl_tx_oob_seq_pkg.sv
// gtxe2_chnl_tx_oob_seq_pkg: shared OOB state/request encodings and default SATA OOB timing
package gtxe2_chnl_tx_oob_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2, DONE = 2'd3} oob_state_e;
  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_INIT = 2'd1, REQ_WAKE = 2'd2, REQ_SAS = 2'd3} oob_req_e;
  localparam logic [3:0] SATA_SEQ_LEN = 4'd6;
  localparam int SATA_BURST_CYCLES = 16;
  localparam int SATA_INIT_GAP = 48;
  localparam int SATA_WAKE_GAP = 16;
  localparam int SATA_SAS_GAP = 144;
  localparam int SATA_CNT_W = 8;
  function automatic oob_req_e oob_req_pick(input logic init, input logic wake, input logic sas);
    return init ? REQ_INIT : wake ? REQ_WAKE : sas ? REQ_SAS : REQ_NONE;
  endfunction
  function automatic logic oob_req_collide(input logic init, input logic wake, input logic sas);
    return (init & (wake | sas)) | (wake & sas);
  endfunction
endpackage

// File: rtl/gtxe2_oob_timer.sv
// gtxe2_oob_timer: loadable down-counter, expired while the count sits at zero
// ports: clk, rst_n (async active-low), load/load_val (count reload), expired
module gtxe2_oob_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/gtxe2_chnl_tx_oob_seq.sv
// gtxe2_chnl_tx_oob_seq: programmable TX OOB burst/gap sequencer (COMINIT/COMWAKE/COMSAS)
// ports: TXUSRCLK2/reset_n, TXCOM* requests, TXELECIDLE, oob_abort -> burst_en, line_idle,
//        oob_busy, burst_idx, TXCOMFINISH, seq_err
module gtxe2_chnl_tx_oob_seq
  import gtxe2_chnl_tx_oob_seq_pkg::*;
#(
  parameter logic [3:0] SATA_BURST_SEQ_LEN = SATA_SEQ_LEN,
  parameter int         BURST_CYCLES       = SATA_BURST_CYCLES,
  parameter int         INIT_GAP_CYCLES    = SATA_INIT_GAP,
  parameter int         WAKE_GAP_CYCLES    = SATA_WAKE_GAP,
  parameter int         SAS_GAP_CYCLES     = SATA_SAS_GAP,
  parameter int         CNT_W              = SATA_CNT_W
) (
  input  logic       TXUSRCLK2,
  input  logic       reset_n,
  input  logic       TXCOMINIT,
  input  logic       TXCOMWAKE,
  input  logic       TXCOMSAS,
  input  logic       TXELECIDLE,
  input  logic       oob_abort,
  output logic       burst_en,
  output logic       line_idle,
  output logic       oob_busy,
  output logic [3:0] burst_idx,
  output logic       TXCOMFINISH,
  output logic       seq_err
);
  localparam int MAX_CYC = (1 << CNT_W) - 1;
  if (BURST_CYCLES < 1 || BURST_CYCLES > MAX_CYC || INIT_GAP_CYCLES < 1 || INIT_GAP_CYCLES > MAX_CYC ||
      WAKE_GAP_CYCLES < 1 || WAKE_GAP_CYCLES > MAX_CYC || SAS_GAP_CYCLES < 1 || SAS_GAP_CYCLES > MAX_CYC) begin : g_cfg_err
    $error("gtxe2_chnl_tx_oob_seq: *_CYCLES must be in 1..2^CNT_W-1");
  end
  localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAS_LD = CNT_W'(SAS_GAP_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = SATA_BURST_SEQ_LEN - 4'd1;
  oob_state_e       state_q, state_d;
  oob_req_e         req_sel;
  logic [2:0]       req_v, req_prev_q, req_prev_d;
  logic [3:0]       burst_idx_q, burst_idx_d;
  logic [CNT_W-1:0] gap_q, gap_d, timer_val;
  logic             burst_en_q, burst_en_d, line_idle_q, line_idle_d, oob_busy_q, oob_busy_d;
  logic             fin_q, fin_d, seq_err_q, seq_err_d, timer_load, timer_exp;
  always_comb begin
    req_v = {TXCOMINIT, TXCOMWAKE, TXCOMSAS};
    req_sel = oob_req_pick(TXCOMINIT, TXCOMWAKE, TXCOMSAS);
    req_prev_d = req_v;
    state_d = state_q;
    burst_idx_d = burst_idx_q;
    gap_d = gap_q;
    seq_err_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (req_sel != REQ_NONE) begin
          state_d = (SATA_BURST_SEQ_LEN == 4'd0) ? DONE : BURST;
          burst_idx_d = '0;
          gap_d = (req_sel == REQ_INIT) ? INIT_LD : (req_sel == REQ_WAKE) ? WAKE_LD : SAS_LD;
          seq_err_d = oob_req_collide(TXCOMINIT, TXCOMWAKE, TXCOMSAS);
        end
      end
      default: begin
        // only a fresh rising request is an error; a level held since acceptance is not
        seq_err_d = |(req_v & ~req_prev_q);
        if (oob_abort) begin
          state_d = IDLE;
          burst_idx_d = '0;
        end else if (timer_exp && state_q == BURST) state_d = GAP;
        else if (timer_exp) begin
          state_d = (burst_idx_q == LAST_IDX) ? DONE : BURST;
          burst_idx_d = (burst_idx_q == LAST_IDX) ? burst_idx_q : burst_idx_q + 4'd1;
        end
      end
    endcase
    burst_en_d = state_d == BURST;
    oob_busy_d = state_d == BURST || state_d == GAP;
    line_idle_d = state_d != BURST;
    fin_d = state_d == DONE;
    timer_load = state_d != state_q;
    timer_val = (state_d == BURST) ? BURST_LD : gap_d;
  end
  always_ff @(posedge TXUSRCLK2 or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      req_prev_q <= '0;
      burst_idx_q <= '0;
      gap_q <= '0;
      burst_en_q <= 1'b0;
      line_idle_q <= 1'b1;
      oob_busy_q <= 1'b0;
      fin_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_prev_q <= req_prev_d;
      burst_idx_q <= burst_idx_d;
      gap_q <= gap_d;
      burst_en_q <= burst_en_d;
      line_idle_q <= line_idle_d;
      oob_busy_q <= oob_busy_d;
      fin_q <= fin_d;
      seq_err_q <= seq_err_d;
    end
  gtxe2_oob_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(TXUSRCLK2),
    .rst_n(reset_n),
    .load(timer_load),
    .load_val(timer_val),
    .expired(timer_exp)
  );
  assign burst_en = burst_en_q;
  assign line_idle = !reset_n | (oob_busy_q ? line_idle_q : TXELECIDLE);
  assign oob_busy = oob_busy_q;
  assign burst_idx = burst_idx_q;
  assign TXCOMFINISH = fin_q;
  assign seq_err = seq_err_q;
endmodule

// File: tb/tb_gtxe2_chnl_tx_oob_seq.sv
// tb_gtxe2_chnl_tx_oob_seq: scoreboard bench for the TX OOB sequencer (default and empty-sequence builds)
module tb_gtxe2_chnl_tx_oob_seq;
  logic clk = 1'b0;
  logic reset_n, TXCOMINIT, TXCOMWAKE, TXCOMSAS, TXELECIDLE, oob_abort, r1;
  logic burst_en, line_idle, oob_busy, fin, seq_err;
  logic burst_en1, line_idle1, oob_busy1, fin1, seq_err1;
  logic [3:0] burst_idx, burst_idx1;
  int cyc = 0, n_chk = 0, n_pass = 0, exp_gap = 48;
  int fq[$], eq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  gtxe2_chnl_tx_oob_seq dut (
    .TXUSRCLK2(clk), .reset_n(reset_n), .TXCOMINIT(TXCOMINIT), .TXCOMWAKE(TXCOMWAKE),
    .TXCOMSAS(TXCOMSAS), .TXELECIDLE(TXELECIDLE), .oob_abort(oob_abort), .burst_en(burst_en),
    .line_idle(line_idle), .oob_busy(oob_busy), .burst_idx(burst_idx), .TXCOMFINISH(fin), .seq_err(seq_err)
  );
  gtxe2_chnl_tx_oob_seq #(.SATA_BURST_SEQ_LEN(4'd0)) dut_len0 (
    .TXUSRCLK2(clk), .reset_n(reset_n), .TXCOMINIT(r1), .TXCOMWAKE(1'b0),
    .TXCOMSAS(1'b0), .TXELECIDLE(TXELECIDLE), .oob_abort(1'b0), .burst_en(burst_en1),
    .line_idle(line_idle1), .oob_busy(oob_busy1), .burst_idx(burst_idx1), .TXCOMFINISH(fin1), .seq_err(seq_err1)
  );
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(input logic i, input logic w, input logic s, input int hold, input bit exp_fin, output int k);
    k = cyc;
    {TXCOMINIT, TXCOMWAKE, TXCOMSAS} = {i, w, s};
    exp_gap = i ? 48 : w ? 16 : 144;
    if (exp_fin) fq.push_back(k + 1 + 6 * (16 + exp_gap));
    if (int'(i) + int'(w) + int'(s) > 1) eq.push_back(k + 1);
    tick(hold);
    {TXCOMINIT, TXCOMWAKE, TXCOMSAS} = 3'b000;
  endtask
  initial begin
    int blen = 0, glen = 0, nb = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        blen = 0;
        glen = 0;
        nb = 0;
      end else begin
        if (glen != 0 && (burst_en || fin)) begin
          chk("gap_len", glen, exp_gap);
          glen = 0;
        end
        if (burst_en) begin
          if (blen == 0) begin
            chk("burst_idx", int'(burst_idx), nb);
            nb++;
          end
          blen++;
        end else if (blen != 0) begin
          chk("burst_len", blen, 16);
          blen = 0;
        end
        if (oob_busy && !burst_en) glen++;
        else if (!oob_busy) glen = 0;
        if (fin) begin
          chk("fin_cyc", cyc, fq.size() != 0 ? fq.pop_front() : -1);
          chk("n_bursts", nb, 6);
        end else if (!oob_busy) nb = 0;
        if (seq_err) chk("err_cyc", cyc, eq.size() != 0 ? eq.pop_front() : -1);
      end
    end
  end
  initial begin
    int k;
    {TXCOMINIT, TXCOMWAKE, TXCOMSAS, oob_abort, r1} = 5'b0;
    TXELECIDLE = 1'b0;
    reset_n = 1'b0;
    tick(2);
    chk("rst_line_idle", int'(line_idle), 1);
    chk("rst_burst_en", int'(burst_en), 0);
    chk("rst_busy", int'(oob_busy), 0);
    chk("rst_idx", int'(burst_idx), 0);
    chk("rst_fin", int'(fin), 0);
    chk("rst_err", int'(seq_err), 0);
    reset_n = 1'b1;
    tick(2);
    chk("idle_pass0", int'(line_idle), 0);
    TXELECIDLE = 1'b1;
    #1 chk("idle_pass1", int'(line_idle), 1);
    tick(1);
    req(1'b1, 1'b0, 1'b0, 1, 1'b1, k);
    tick(400);
    chk("init_busy_after", int'(oob_busy), 0);
    req(1'b0, 1'b1, 1'b0, 3, 1'b1, k);
    tick(210);
    chk("wake_busy_after", int'(oob_busy), 0);
    req(1'b1, 1'b0, 1'b1, 1, 1'b1, k);
    tick(400);
    req(1'b0, 1'b0, 1'b1, 1, 1'b1, k);
    tick(980);
    chk("sas_busy_after", int'(oob_busy), 0);
    req(1'b1, 1'b0, 1'b0, 1, 1'b0, k);
    tick(k + 70 - cyc);
    TXCOMSAS = 1'b1;
    eq.push_back(cyc + 1);
    tick(2);
    TXCOMSAS = 1'b0;
    tick(k + 230 - cyc);
    TXELECIDLE = 1'b0;
    oob_abort = 1'b1;
    #1 chk("gap_line_idle", int'(line_idle), 1);
    chk("gap_idx", int'(burst_idx), 3);
    tick(1);
    oob_abort = 1'b0;
    chk("abort_burst_en", int'(burst_en), 0);
    chk("abort_busy", int'(oob_busy), 0);
    chk("abort_idx", int'(burst_idx), 0);
    chk("abort_line_idle0", int'(line_idle), 0);
    TXELECIDLE = 1'b1;
    #1 chk("abort_line_idle1", int'(line_idle), 1);
    tick(300);
    req(1'b0, 1'b1, 1'b0, 1, 1'b0, k);
    tick(4);
    chk("pre_rst_burst", int'(burst_en), 1);
    #2 reset_n = 1'b0;
    #1 chk("async_burst_en", int'(burst_en), 0);
    chk("async_busy", int'(oob_busy), 0);
    chk("async_line_idle", int'(line_idle), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(2);
    req(1'b0, 1'b1, 1'b0, 1, 1'b1, k);
    tick(210);
    r1 = 1'b1;
    tick(1);
    r1 = 1'b0;
    chk("len0_fin", int'(fin1), 1);
    chk("len0_burst", int'(burst_en1), 0);
    chk("len0_busy", int'(oob_busy1), 0);
    tick(1);
    chk("len0_fin_once", int'(fin1), 0);
    chk("len0_burst2", int'(burst_en1), 0);
    chk("len0_idx", int'(burst_idx1), 0);
    chk("len0_err", int'(seq_err1), 0);
    chk("len0_line_idle", int'(line_idle1), 1);
    tick(5);
    chk("fin_left", fq.size(), 0);
    chk("err_left", eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
